dmem_responder: RTL

//   Responder end of the data-cache refill/write-back interface: a line-wide
//   (256-bit) data memory that serves the dcache controller's enable/write/ack

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_line_array.sv | 25 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-wide data-memory responder.
// Holds the line geometry, the FSM state encoding and the latency counter sizing.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // The counter only ever holds LATENCY-1, so LATENCY==1 or 2 needs a single bit.
  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage: synchronous write, combinational read, no reset.
// Pure storage; all sequencing lives in dmem_responder.
module dmem_line_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] lines [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      lines[idx] <= wdata;
    end
  end

  assign rdata = lines[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the dcache refill/write-back interface: fixed-latency line
// memory with a one-cycle ack. Optional checker enabled by DMEM_PROTOCOL_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for mem_enable_i; request latched on acceptance
//   WAIT  | counting down the access latency from latched request
//   ACK   | mem_ack_o high for this one cycle; enable not sampled
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              proto_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [LINE_W-1:0] data_q;

  logic              go_ack;
  logic              srv_wr;
  logic [IDX_W-1:0]  srv_idx;
  logic [LINE_W-1:0] srv_data;
  logic [LINE_W-1:0] rd_data;
  logic              unused_addr;

  // With LATENCY==1 the access completes at the accepting edge, so the live
  // inputs are served instead of the (not yet loaded) latched copies.
  always_comb begin
    srv_wr   = wr_q;
    srv_idx  = addr_q[OFFSET_W +: IDX_W];
    srv_data = data_q;
    go_ack   = 1'b0;
    if (state == IDLE) begin
      srv_wr   = mem_write_i;
      srv_idx  = mem_addr_i[OFFSET_W +: IDX_W];
      srv_data = mem_data_i;
      go_ack   = mem_enable_i && (LATENCY == 1);
    end else if (state == WAIT) begin
      go_ack = (cnt == CNT_W'(1));
    end
  end

  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .we    (go_ack && srv_wr),
    .idx   (srv_idx),
    .wdata (srv_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      mem_ack_o <= go_ack;
      if (go_ack && !srv_wr) begin
        mem_data_o <= rd_data;
      end
      case (state)
        IDLE: begin
          if (mem_enable_i) begin
            addr_q <= mem_addr_i;
            wr_q   <= mem_write_i;
            data_q <= mem_data_i;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= (LATENCY == 1) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic viol;

  assign viol = (state == WAIT) &&
                ((mem_addr_i != addr_q) || (mem_write_i != wr_q) ||
                 (wr_q && (mem_data_i != data_q)) || !mem_enable_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      proto_err_o <= 1'b0;
    end else if (viol) begin
      proto_err_o <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_i && viol) begin
      $error("dmem_responder: request changed while waiting for ack");
    end
  end
`endif
`else
  assign proto_err_o = 1'b0;
`endif

  // Offset and high address bits never select a line; only the checker reads addr_q whole.
  assign unused_addr = ^{mem_addr_i, addr_q};

endmodule
